// File: rtl/ms_fifo_pkg.sv
// ms_fifo_pkg: shared register map, bit positions and address decode for ms_fifo_ahbl.
//   Offsets are HADDR[7:0]; reg_sel_e is the decoded register carried into the data phase.
package ms_fifo_pkg;

   localparam logic [7:0] AddrData   = 8'h00;
   localparam logic [7:0] AddrStatus = 8'h04;
   localparam logic [7:0] AddrThresh = 8'h08;
   localparam logic [7:0] AddrCtrl   = 8'h0C;
   localparam logic [7:0] AddrOvfclr = 8'h10;

   localparam int unsigned CtrlEnBit    = 0;
   localparam int unsigned CtrlFlushBit = 1;
   localparam int unsigned CtrlIeBit    = 2;

   localparam int unsigned StatEmptyBit = 0;
   localparam int unsigned StatFullBit  = 1;
   localparam int unsigned StatOvfBit   = 2;
   localparam int unsigned StatLevelLsb = 8;

   localparam logic [31:0] DefaultRdata = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      RegData,
      RegStatus,
      RegThresh,
      RegCtrl,
      RegOvfclr,
      RegNone
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [7:0] addr);
      reg_sel_e sel;
      case (addr)
         AddrData:   sel = RegData;
         AddrStatus: sel = RegStatus;
         AddrThresh: sel = RegThresh;
         AddrCtrl:   sel = RegCtrl;
         AddrOvfclr: sel = RegOvfclr;
         default:    sel = RegNone;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ms_fifo_ahbl_if.sv
// ms_fifo_ahbl_if: AHB-Lite slave-side bus bundle.
//   master modport: drives address/control/write data, sees HREADY, HREADYOUT, HRDATA.
//   slave modport : sees address/control/write data and HREADY, drives HREADYOUT, HRDATA.
interface ms_fifo_ahbl_if;

   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HREADY, HREADYOUT, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output HREADYOUT, HRDATA
   );

endinterface

// File: rtl/ms_sync_fifo.sv
// ms_sync_fifo: single-clock FIFO storage with pointers and occupancy count.
//   HCLK, HRESETn : clock, synchronous active-low reset (pointers and level only)
//   push/push_data: write a word (ignored when full)
//   pop           : drop the head word (ignored when empty)
//   flush         : empty the FIFO, overriding a same-cycle push/pop
//   data          : head word, zero while empty
//   full/empty    : occupancy flags; level: 0..DEPTH
module ms_sync_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [DATA_W-1:0]        data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              do_push, do_pop;

   always_comb begin
      full    = (level_q == LW'(DEPTH));
      empty   = (level_q == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      level   = level_q;
      data    = empty ? '0 : mem_q[rd_ptr_q];
   end

   // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
   always_ff @(posedge HCLK) begin
      if (!HRESETn || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ms_fifo_ahbl.sv
// ms_fifo_ahbl: AHB-Lite fed FIFO with a streaming output and a low-level interrupt.
//   HCLK, HRESETn : clock, synchronous active-low reset
//   ahb           : AHB-Lite slave port (registers DATA/STATUS/THRESH/CTRL/OVFCLR)
//   IRQ           : IE & EN & (LEVEL <= THRESH), asks an upstream DMA to refill
//   OUT_DATA      : head-of-FIFO word; OUT_VALID: not empty and EN set
//   OUT_READY     : consumer accepts OUT_DATA (pops on OUT_VALID & OUT_READY)
module ms_fifo_ahbl
   import ms_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned THR_W = $clog2(DEPTH) + 1
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ms_fifo_ahbl_if.slave       ahb,
   output logic                IRQ,
   output logic [31:0]         OUT_DATA,
   output logic                OUT_VALID,
   input  logic                OUT_READY
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   // Data-phase state captured from the address phase.
   logic         dp_valid_q;
   logic         dp_write_q;
   reg_sel_e     dp_sel_q;

   logic         en_q, ie_q, ovf_q;
   logic [THR_W-1:0] thresh_q;

   logic             fifo_full, fifo_empty;
   logic [LVL_W-1:0] fifo_level;
   logic [31:0]      fifo_head;

   logic         wr_active, wr_data, stall, push, pop, flush;
   logic [31:0]  level_ext, status_word, ctrl_word;
   logic         unused_ok;

   assign unused_ok = ^{ahb.HSIZE, ahb.HADDR[31:8], ahb.HTRANS[0]};

   always_comb begin
      wr_active = dp_valid_q & dp_write_q;
      wr_data   = wr_active & (dp_sel_q == RegData);
      // A DATA write only waits when the FIFO is enabled; disabled writes are dropped.
      stall     = wr_data & en_q & fifo_full;
      push      = wr_data & en_q & ~fifo_full;
      flush     = wr_active & (dp_sel_q == RegCtrl) & ahb.HWDATA[CtrlFlushBit];
      OUT_VALID = en_q & ~fifo_empty;
      OUT_DATA  = fifo_head;
      pop       = OUT_VALID & OUT_READY;
      ahb.HREADYOUT = ~stall;
   end

   ms_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (32)
   ) u_fifo (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .push      (push),
      .push_data (ahb.HWDATA),
      .pop       (pop),
      .flush     (flush),
      .data      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Address phase is only taken while the bus is ready, so a stalled DATA write
   // keeps its data-phase slot until space appears.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_sel_q   <= RegNone;
      end else if (ahb.HREADY) begin
         dp_valid_q <= ahb.HSEL & ahb.HTRANS[1];
         dp_write_q <= ahb.HWRITE;
         dp_sel_q   <= decode_addr(ahb.HADDR[7:0]);
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         ovf_q    <= 1'b0;
         thresh_q <= '0;
      end else begin
         if (wr_active && (dp_sel_q == RegThresh)) begin
            thresh_q <= ahb.HWDATA[THR_W-1:0];
         end
         if (wr_active && (dp_sel_q == RegCtrl)) begin
            en_q <= ahb.HWDATA[CtrlEnBit];
            ie_q <= ahb.HWDATA[CtrlIeBit];
         end
         if (wr_data && !en_q) begin
            ovf_q <= 1'b1;
         end else if (wr_active && (dp_sel_q == RegOvfclr) && ahb.HWDATA[0]) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_comb begin
      level_ext   = 32'(fifo_level);
      status_word = '0;
      status_word[StatEmptyBit] = fifo_empty;
      status_word[StatFullBit]  = fifo_full;
      status_word[StatOvfBit]   = ovf_q;
      status_word[StatLevelLsb +: 8] = level_ext[7:0];

      ctrl_word = '0;
      ctrl_word[CtrlEnBit] = en_q;
      ctrl_word[CtrlIeBit] = ie_q;

      case (dp_sel_q)
         RegData:   ahb.HRDATA = fifo_head;
         RegStatus: ahb.HRDATA = status_word;
         RegThresh: ahb.HRDATA = 32'(thresh_q);
         RegCtrl:   ahb.HRDATA = ctrl_word;
         RegOvfclr: ahb.HRDATA = '0;
         default:   ahb.HRDATA = DefaultRdata;
      endcase

      IRQ = ie_q & en_q & (level_ext <= 32'(thresh_q));
   end

endmodule

// File: tb/tb_ms_fifo_ahbl.sv
module tb_ms_fifo_ahbl;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        IRQ;
   logic [31:0] OUT_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;

   int n_checks = 0;
   int n_fail   = 0;

   ms_fifo_ahbl_if bus ();

   // Single-slave bus: the global HREADY is this slave's HREADYOUT.
   assign bus.HREADY = bus.HREADYOUT;

   ms_fifo_ahbl #(
      .DEPTH (16)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .ahb       (bus),
      .IRQ       (IRQ),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
   endtask

   task automatic addr_phase(input logic [7:0] a, input logic wr);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = {24'h0, a};
      bus.HWRITE = wr;
      bus.HSIZE  = 3'b010;
   endtask

   task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, output int stalls);
      addr_phase(a, 1'b1);
      tick();
      bus_idle();
      bus.HWDATA = d;
      stalls = 0;
      while (!bus.HREADYOUT && stalls < 50) begin
         tick();
         stalls++;
      end
      tick();
   endtask

   task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
      addr_phase(a, 1'b0);
      tick();
      bus_idle();
      d = bus.HRDATA;
      tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      int s;
      ahb_write(a, d, s);
      check($sformatf("stall_wr_%02h", a), s, 0);
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      ahb_read(a, d);
      check(tag, d, exp);
   endtask

   // 17 back-to-back DATA writes; returns sitting in the stalled 17th data phase.
   task automatic fill_stall(input logic [31:0] base);
      for (int i = 0; i < 17; i++) begin
         addr_phase(8'h00, 1'b1);
         if (i > 0) bus.HWDATA = base + 32'(i - 1);
         tick();
      end
      bus_idle();
      bus.HWDATA = base + 32'd16;
   endtask

   task automatic pulse_ready();
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
   endtask

   logic [31:0] w [13];

   initial begin
      HRESETn    = 1'b0;
      OUT_READY  = 1'b0;
      bus.HADDR  = '0;
      bus.HWDATA = '0;
      bus.HSIZE  = 3'b010;
      bus_idle();
      for (int k = 0; k < 13; k++) w[k] = 32'h3100_0000 + 32'(k);
      repeat (3) tick();
      HRESETn = 1'b1;

      // Reset state
      check_bit("rst_hreadyout", bus.HREADYOUT, 1'b1);
      check_bit("rst_out_valid", OUT_VALID, 1'b0);
      check_bit("rst_irq", IRQ, 1'b0);
      check("rst_out_data", OUT_DATA, 32'h0);
      rd_check("rst_status", 8'h04, 32'h0000_0001);
      rd_check("rst_ctrl", 8'h0C, 32'h0);

      // Single push, consumer not ready
      wr(8'h0C, 32'h1);
      wr(8'h00, 32'hA5A5_A5A5);
      check_bit("push1_valid", OUT_VALID, 1'b1);
      check("push1_data", OUT_DATA, 32'hA5A5_A5A5);
      rd_check("push1_peek", 8'h00, 32'hA5A5_A5A5);
      rd_check("push1_status", 8'h04, 32'h0000_0100);

      // Flush; FLUSH reads back as 0
      wr(8'h0C, 32'h3);
      rd_check("flush_status", 8'h04, 32'h0000_0001);
      rd_check("flush_ctrl", 8'h0C, 32'h0000_0001);

      // Overfill: 17th write stalls until one pop frees a slot
      fill_stall(32'h1000_0000);
      for (int k = 0; k < 3; k++) begin
         check_bit($sformatf("full_stall_%0d", k), bus.HREADYOUT, 1'b0);
         tick();
      end
      check_bit("full_still_stalled", bus.HREADYOUT, 1'b0);
      check("full_head", OUT_DATA, 32'h1000_0000);
      pulse_ready();
      check_bit("full_released", bus.HREADYOUT, 1'b1);
      tick();
      check("full_head_after_pop", OUT_DATA, 32'h1000_0001);
      rd_check("full_status", 8'h04, 32'h0000_1002);

      // Flush a full FIFO with a DATA write right behind it
      addr_phase(8'h0C, 1'b1);
      tick();
      bus.HWDATA = 32'h3;
      addr_phase(8'h00, 1'b1);
      tick();
      bus_idle();
      bus.HWDATA = 32'h0000_0077;
      check_bit("flush_full_ready", bus.HREADYOUT, 1'b1);
      check_bit("flush_full_empty", OUT_VALID, 1'b0);
      tick();
      check_bit("flush_push_valid", OUT_VALID, 1'b1);
      check("flush_push_data", OUT_DATA, 32'h0000_0077);
      rd_check("flush_push_status", 8'h04, 32'h0000_0100);

      // Steady stream at LEVEL 5: push and pop every cycle
      wr(8'h0C, 32'h3);
      for (int k = 0; k < 5; k++) wr(8'h00, w[k]);
      rd_check("stream_pre_status", 8'h04, 32'h0000_0500);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) addr_phase(8'h00, 1'b1);
         else bus_idle();
         if (i > 0) begin
            bus.HWDATA = w[4 + i];
            OUT_READY  = 1'b1;
            check($sformatf("stream_out_%0d", i - 1), OUT_DATA, w[i - 1]);
         end
         tick();
      end
      OUT_READY = 1'b0;
      rd_check("stream_post_status", 8'h04, 32'h0000_0500);
      check("stream_head", OUT_DATA, w[8]);

      // Low-level interrupt with THRESH = 2
      wr(8'h0C, 32'h7);
      wr(8'h08, 32'h2);
      rd_check("thresh_rb", 8'h08, 32'h2);
      rd_check("ctrl_ie_rb", 8'h0C, 32'h5);
      check_bit("irq_lvl0", IRQ, 1'b1);
      for (int k = 0; k < 4; k++) wr(8'h00, 32'h4400_0000 + 32'(k));
      check_bit("irq_lvl4", IRQ, 1'b0);
      pulse_ready();
      check_bit("irq_lvl3", IRQ, 1'b0);
      pulse_ready();
      check_bit("irq_lvl2", IRQ, 1'b1);
      rd_check("irq_status", 8'h04, 32'h0000_0200);

      // Disabled FIFO drops writes and flags OVF
      wr(8'h0C, 32'h2);
      wr(8'h00, 32'h1234_5678);
      check_bit("dis_valid", OUT_VALID, 1'b0);
      rd_check("dis_status", 8'h04, 32'h0000_0005);
      wr(8'h10, 32'h1);
      rd_check("ovfclr_status", 8'h04, 32'h0000_0001);
      rd_check("unmapped", 8'h40, 32'hDEAD_BEEF);

      // Reset in the middle of a stalled write
      wr(8'h0C, 32'h1);
      fill_stall(32'h2000_0000);
      check_bit("rst_stall_pre", bus.HREADYOUT, 1'b0);
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      check_bit("rst_stall_ready", bus.HREADYOUT, 1'b1);
      check_bit("rst_stall_valid", OUT_VALID, 1'b0);
      rd_check("rst_stall_status", 8'h04, 32'h0000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
